rst_seq_ctrl: RTL and testbench

- Parametrised successor to the board reset controller.
- Produces NumDomains active-low reset outputs from one buffered board clock. Outputs are released in a fixed sequence: domain 0 first (e.g. system), later domains follow (e.g. USB, HyperRAM).
- Reset sources: PLL lock, debounced reset button, software reset request, and the synchronous controller reset.
- Loss of any source re-asserts all domains at once. A sticky reset-cause register is kept for software.

---
 rtl/rst_seq_ctrl_pkg.sv | 11 +
 rtl/rst_seq_filter.sv | 36 +++
 rtl/rst_seq_ctrl.sv | 100 ++++++++++
 tb/tb_rst_seq_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/rst_seq_ctrl_pkg.sv
// rst_seq_ctrl_pkg: shared states, cause bit indices and counter sizing for the reset sequencer
package rst_seq_ctrl_pkg;
  typedef enum logic [1:0] {RstAssert, RstRelease, RstRun} rst_seq_state_e;
  localparam int RstCausePor = 0;
  localparam int RstCauseBtn = 1;
  localparam int RstCauseLock = 2;
  localparam int RstCauseSw = 3;
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
endpackage

// File: rtl/rst_seq_filter.sv
// rst_seq_filter: 2-flop synchroniser plus stable-count filter, optional immediate fall
module rst_seq_filter #(
  parameter int Cycles = 8,
  parameter bit FastFall = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic filt_o
);
  localparam int CW = $clog2(Cycles + 1);
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q;
  logic s;
  assign s = sync_q[1];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      cnt_q <= '0;
      filt_o <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], async_i};
      if (FastFall && filt_o && !s) begin
        filt_o <= 1'b0;
        cnt_q <= '0;
      end else if (s == filt_o) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(Cycles - 1)) begin
        filt_o <= s;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: sequenced multi-domain reset release with abort on source loss and sticky cause
module rst_seq_ctrl
  import rst_seq_ctrl_pkg::*;
#(
  parameter int NumDomains = 3,
  parameter int PowerOnCycles = 255,
  parameter int StageGapCycles = 16,
  parameter int DebounceCycles = 1000,
  parameter int LockFilterCycles = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  pll_locked_i,
  input  logic                  rst_btn_i,
  input  logic                  sw_rst_req_i,
  input  logic                  rst_cause_clr_i,
  output logic [NumDomains-1:0] rst_no,
  output logic [3:0]            rst_cause_o,
  output logic                  busy_o
);
  localparam int CW = cnt_width(PowerOnCycles, StageGapCycles);
  localparam int IW = $clog2(NumDomains + 1);
  rst_seq_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NumDomains-1:0] rst_d;
  logic [3:0] set, cause_d;
  logic lock_ok, btn_db, good, abort;
  rst_seq_filter #(.Cycles(LockFilterCycles), .FastFall(1'b1)) u_lock_filt (
    .clk_i(clk_i), .rst_i(rst_i), .async_i(pll_locked_i), .filt_o(lock_ok)
  );
  rst_seq_filter #(.Cycles(DebounceCycles), .FastFall(1'b0)) u_btn_filt (
    .clk_i(clk_i), .rst_i(rst_i), .async_i(rst_btn_i), .filt_o(btn_db)
  );
  assign good = lock_ok && !btn_db;
  assign abort = (state_q != RstAssert) && (!lock_ok || btn_db || sw_rst_req_i);
  assign busy_o = state_q != RstRun;
  always_comb begin
    set = '0;
    set[RstCauseBtn] = btn_db;
    set[RstCauseLock] = !lock_ok;
    set[RstCauseSw] = sw_rst_req_i;
    set = (state_q == RstAssert) ? 4'b0 : set;
    cause_d = (rst_cause_clr_i ? 4'b0 : rst_cause_o) | set;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    rst_d = rst_no;
    if (abort) begin
      state_d = RstAssert;
      cnt_d = '0;
      idx_d = '0;
      rst_d = '0;
    end else begin
      case (state_q)
        RstAssert: begin
          rst_d = '0;
          idx_d = '0;
          cnt_d = good ? cnt_q + 1'b1 : '0;
          if (good && cnt_q == CW'(PowerOnCycles - 1)) begin
            cnt_d = '0;
            rst_d[0] = 1'b1;
            idx_d = IW'(1);
            state_d = (NumDomains == 1) ? RstRun : RstRelease;
          end
        end
        RstRelease: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(StageGapCycles - 1)) begin
            cnt_d = '0;
            rst_d = rst_no | (NumDomains'(1) << idx_q);
            idx_d = idx_q + 1'b1;
            state_d = (idx_q == IW'(NumDomains - 1)) ? RstRun : RstRelease;
          end
        end
        default: begin
          rst_d = '1;
          cnt_d = '0;
        end
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RstAssert;
      cnt_q <= '0;
      idx_q <= '0;
      rst_no <= '0;
      rst_cause_o <= 4'b0001;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      rst_no <= rst_d;
      rst_cause_o <= cause_d;
    end
  end
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: directed vector table plus randomized run against a timing-rule reference model
module tb_rst_seq_ctrl;
  localparam int ND = 3;
  localparam int POC = 20;
  localparam int GAP = 4;
  localparam int DBC = 10;
  localparam int LFC = 8;
  logic clk = 1'b0;
  logic rst = 1'b1, lock = 1'b1, btn = 1'b0, sw = 1'b0, clr = 1'b0;
  logic [ND-1:0] rst_no;
  logic [3:0] cause;
  logic busy;
  int checks = 0;
  int errors = 0;
  rst_seq_ctrl #(
    .NumDomains(ND), .PowerOnCycles(POC), .StageGapCycles(GAP),
    .DebounceCycles(DBC), .LockFilterCycles(LFC)
  ) dut (
    .clk_i(clk), .rst_i(rst), .pll_locked_i(lock), .rst_btn_i(btn),
    .sw_rst_req_i(sw), .rst_cause_clr_i(clr),
    .rst_no(rst_no), .rst_cause_o(cause), .busy_o(busy)
  );
  always #5 clk = ~clk;
  bit m_sl1, m_sl2, m_sb1, m_sb2, m_lock_ok, m_db, m_rel, m_blast;
  int m_lrun, m_brun, m_good, m_age;
  logic [3:0] m_cause;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic model_update();
    bit good, ab, ls, bs;
    if (rst) begin
      {m_sl1, m_sl2, m_sb1, m_sb2, m_lock_ok, m_db, m_rel, m_blast} = '0;
      m_lrun = 0; m_brun = 0; m_good = 0; m_age = 0;
      m_cause = 4'b0001;
    end else begin
      good = m_lock_ok && !m_db;
      ab = m_rel && (!m_lock_ok || m_db || sw);
      m_cause = (clr ? 4'b0 : m_cause) | (m_rel ? {sw, !m_lock_ok, m_db, 1'b0} : 4'b0);
      if (ab) begin
        m_rel = 0; m_good = 0;
      end else if (m_rel) begin
        m_age = (m_age < 1000) ? m_age + 1 : m_age;
      end else if (good) begin
        m_good++;
        if (m_good == POC) begin m_rel = 1; m_age = 0; m_good = 0; end
      end else begin
        m_good = 0;
      end
      ls = m_sl2;
      bs = m_sb2;
      m_lrun = ls ? ((m_lrun < 1000) ? m_lrun + 1 : m_lrun) : 0;
      m_lock_ok = m_lrun >= LFC;
      m_brun = (bs == m_blast) ? ((m_brun < 100000) ? m_brun + 1 : m_brun) : 1;
      m_blast = bs;
      if (bs != m_db && m_brun >= DBC) m_db = bs;
      m_sl2 = m_sl1; m_sl1 = lock;
      m_sb2 = m_sb1; m_sb1 = btn;
    end
  endtask
  task automatic step();
    logic [ND-1:0] e;
    @(posedge clk);
    model_update();
    #1;
    for (int k = 0; k < ND; k++) e[k] = m_rel && (m_age >= k * GAP);
    chk("model_rst_no", 32'(rst_no), 32'(e));
    chk("model_busy", 32'(busy), 32'(!(m_rel && m_age >= (ND - 1) * GAP)));
    chk("model_cause", 32'(cause), 32'(m_cause));
  endtask
  typedef struct {
    int n;
    logic r, l, b, s, c;
    logic [2:0] eq;
    logic eb;
    logic [3:0] ec;
  } vec_t;
  vec_t v[$];
  initial begin
    v.push_back('{3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 4'b0001});
    v.push_back('{29, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 4'b0001});
    v.push_back('{1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 4'b0001});
    v.push_back('{3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 4'b0001});
    v.push_back('{1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b011, 1'b1, 4'b0001});
    v.push_back('{3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b011, 1'b1, 4'b0001});
    v.push_back('{1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 4'b0001});
    v.push_back('{1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 4'b0001});
    v.push_back('{2,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 4'b0001});
    v.push_back('{1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 4'b0101});
    v.push_back('{26, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 4'b0101});
    v.push_back('{1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 4'b0101});
    v.push_back('{8,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 4'b0101});
    v.push_back('{5,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 4'b0101});
    v.push_back('{15, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 4'b0101});
    v.push_back('{12, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 4'b0101});
    v.push_back('{1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 4'b0111});
    v.push_back('{30, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 4'b0111});
    v.push_back('{1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 4'b0111});
    v.push_back('{1,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 4'b1111});
    v.push_back('{5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 4'b1111});
    v.push_back('{1,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 4'b1111});
    v.push_back('{13, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 4'b1111});
    v.push_back('{1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 4'b1111});
    v.push_back('{8,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 4'b1111});
    v.push_back('{1,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 1'b1, 4'b1000});
    v.push_back('{1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 4'b0000});
    v.push_back('{19, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 4'b0000});
    v.push_back('{5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b011, 1'b1, 4'b0000});
    v.push_back('{1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 4'b0001});
    v.push_back('{29, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 4'b0001});
    v.push_back('{1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 4'b0001});
    for (int i = 0; i < v.size(); i++) begin
      rst = v[i].r; lock = v[i].l; btn = v[i].b; sw = v[i].s; clr = v[i].c;
      repeat (v[i].n) step();
      chk($sformatf("vec%0d_rst_no", i), 32'(rst_no), 32'(v[i].eq));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(v[i].eb));
      chk($sformatf("vec%0d_cause", i), 32'(cause), 32'(v[i].ec));
    end
    rst = 1'b0; lock = 1'b1; btn = 1'b0; sw = 1'b0; clr = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      lock = lock ? ($urandom_range(0, 199) != 0) : ($urandom_range(0, 9) < 4);
      btn = btn ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 149) == 0);
      sw = $urandom_range(0, 79) == 0;
      clr = $urandom_range(0, 49) == 0;
      rst = $urandom_range(0, 999) == 0;
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
